// File: rtl/multicycle_controller_pkg.sv
// Shared control definitions for the multicycle RV32I controller:
// opcodes, funct codes, datapath select encodings, FSM states and fault codes.
package multicycle_controller_pkg;

  localparam int IMM_TYPE_WIDTH = 3;
  localparam int ALUOP_WIDTH    = 4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_I = 3'd0;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_S = 3'd1;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_B = 3'd2;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_U = 3'd3;
  localparam logic [IMM_TYPE_WIDTH-1:0] IMM_J = 3'd4;

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD    = 4'd0;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB    = 4'd1;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLL    = 4'd2;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLT    = 4'd3;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLTU   = 4'd4;
  localparam logic [ALUOP_WIDTH-1:0] ALU_XOR    = 4'd5;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRL    = 4'd6;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SRA    = 4'd7;
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR     = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND    = 4'd9;
  localparam logic [ALUOP_WIDTH-1:0] ALU_COPY_B = 4'd10;

  localparam logic       PC_PLUS_4 = 1'b0;
  localparam logic       PC_ALU    = 1'b1;
  localparam logic       A_REG     = 1'b0;
  localparam logic       A_PC      = 1'b1;
  localparam logic       B_REG     = 1'b0;
  localparam logic       B_IMM     = 1'b1;
  localparam logic [1:0] WB_MEM    = 2'd0;
  localparam logic [1:0] WB_ALU    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // Load selects reuse the RV32I load funct3 values directly.
  localparam logic [2:0] LD_BYTE   = 3'b000;
  localparam logic [2:0] LD_HALF   = 3'b001;
  localparam logic [2:0] LD_WORD   = 3'b010;
  localparam logic [2:0] LD_BYTE_U = 3'b100;
  localparam logic [2:0] LD_HALF_U = 3'b101;

  localparam logic [3:0] STR_BYTE = 4'b0001;
  localparam logic [3:0] STR_HALF = 4'b0011;
  localparam logic [3:0] STR_WORD = 4'b1111;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_SYSTEM  = 2'd2;
  localparam logic [1:0] FAULT_FETCH   = 2'd3;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  function automatic logic [ALUOP_WIDTH-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/data memory handshake between the controller (master) and memories (slave).
interface multicycle_controller_if #(
  parameter int DWIDTH = 32
);
  logic                  imem_req;
  logic                  imem_ready;
  logic                  dmem_req;
  logic                  dmem_ready;
  logic [DWIDTH/8-1:0]   dmem_wbe;

  modport master (output imem_req, dmem_req, dmem_wbe, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_wbe, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// Combinational RV32I field decode: datapath selects, store mask, class flags,
// branch resolution and illegal/system detection for the instruction in IR.
module instr_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [31:0]               instr,
  input  logic                      br_eq,
  input  logic                      br_lt,
  output logic [IMM_TYPE_WIDTH-1:0] imm_sel,
  output logic                      a_sel,
  output logic                      b_sel,
  output logic [ALUOP_WIDTH-1:0]    alu_sel,
  output logic                      br_un,
  output logic [2:0]                ld_sel,
  output logic [1:0]                wb_sel,
  output logic [3:0]                str_mask,
  output logic                      is_load,
  output logic                      is_store,
  output logic                      is_branch,
  output logic                      pc_alu,
  output logic                      illegal,
  output logic                      system
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    imm_sel   = IMM_I;
    a_sel     = A_REG;
    b_sel     = B_IMM;
    alu_sel   = ALU_ADD;
    br_un     = 1'b0;
    ld_sel    = f3;
    wb_sel    = WB_ALU;
    str_mask  = 4'b0000;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    pc_alu    = 1'b0;
    illegal   = 1'b0;
    system    = 1'b0;
    case (opcode)
      OP_LUI: begin
        imm_sel = IMM_U;
        alu_sel = ALU_COPY_B;
      end
      OP_AUIPC: begin
        imm_sel = IMM_U;
        a_sel   = A_PC;
      end
      OP_JAL: begin
        imm_sel = IMM_J;
        a_sel   = A_PC;
        wb_sel  = WB_PC;
        pc_alu  = 1'b1;
      end
      OP_JALR: begin
        wb_sel  = WB_PC;
        pc_alu  = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        // funct3[2] selects lt vs eq, funct3[0] inverts, funct3[1] marks unsigned.
        imm_sel   = IMM_B;
        a_sel     = A_PC;
        is_branch = 1'b1;
        br_un     = f3[1];
        pc_alu    = (f3[2] ? br_lt : br_eq) ^ f3[0];
        illegal   = (f3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        is_load = 1'b1;
        wb_sel  = WB_MEM;
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        imm_sel  = IMM_S;
        is_store = 1'b1;
        case (f3)
          F3_SB:   str_mask = STR_BYTE;
          F3_SH:   str_mask = STR_HALF;
          F3_SW:   str_mask = STR_WORD;
          default: illegal  = 1'b1;
        endcase
      end
      OP_IMM: begin
        alu_sel = alu_op(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL)
          illegal = (f7 != F7_BASE);
        else if (f3 == F3_SR)
          illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OP_REG: begin
        b_sel   = B_REG;
        alu_sel = alu_op(f3, f7[5]);
        illegal = !((f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR))));
      end
      OP_SYSTEM: system  = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with fetch
// wait-cycle watchdog; field decode lives in instr_decoder.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int DWIDTH        = 32,
  parameter int IMEM_WAIT_MAX = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH-1:0]         instr,
  multicycle_controller_if.master   mem,
  input  logic                      br_eq,
  input  logic                      br_lt,
  output logic                      br_un,
  output logic                      ir_we,
  output logic                      pc_we,
  output logic                      rf_we,
  output logic                      pc_sel,
  output logic [IMM_TYPE_WIDTH-1:0] imm_sel,
  output logic                      a_sel,
  output logic                      b_sel,
  output logic [ALUOP_WIDTH-1:0]    alu_sel,
  output logic [2:0]                ld_sel,
  output logic [1:0]                wb_sel,
  output logic                      retire,
  output logic                      halted,
  output logic [1:0]                fault_cause
);
  localparam int                WAIT_W    = $clog2(IMEM_WAIT_MAX + 1);
  localparam int                WBE_W     = DWIDTH / 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_WAIT_MAX - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]        fault_nxt;
  logic [3:0]        str_mask;
  logic              is_load, is_store, is_branch, pc_alu, illegal, system;

  instr_decoder u_dec (
    .instr     (instr[31:0]),
    .br_eq     (br_eq),
    .br_lt     (br_lt),
    .imm_sel   (imm_sel),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .alu_sel   (alu_sel),
    .br_un     (br_un),
    .ld_sel    (ld_sel),
    .wb_sel    (wb_sel),
    .str_mask  (str_mask),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .pc_alu    (pc_alu),
    .illegal   (illegal),
    .system    (system)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      fault_cause <= FAULT_NONE;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      fault_cause <= fault_nxt;
    end
  end

  // Strobes are gated by rst so a mid-MEM or mid-FETCH reset cycle stays quiet.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = '0;
    fault_nxt     = fault_cause;
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_wbe  = '0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    pc_sel        = PC_PLUS_4;
    retire        = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            ir_we     = 1'b1;
            state_nxt = DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = HALT;
            fault_nxt = FAULT_FETCH;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        DECODE: begin
          if (illegal) begin
            state_nxt = HALT;
            fault_nxt = FAULT_ILLEGAL;
          end else if (system) begin
            state_nxt = HALT;
            fault_nxt = FAULT_SYSTEM;
          end else begin
            state_nxt = EXEC;
          end
        end
        EXEC: state_nxt = (is_load || is_store) ? MEM : WB;
        MEM: begin
          mem.dmem_req = 1'b1;
          if (is_store) mem.dmem_wbe = WBE_W'(str_mask);
          if (mem.dmem_ready) begin
            if (is_store) begin
              pc_we     = 1'b1;
              retire    = 1'b1;
              state_nxt = FETCH;
            end else begin
              state_nxt = WB;
            end
          end
        end
        WB: begin
          rf_we     = !is_branch;
          pc_we     = 1'b1;
          retire    = 1'b1;
          pc_sel    = pc_alu ? PC_ALU : PC_PLUS_4;
          state_nxt = FETCH;
        end
        HALT:    halted    = 1'b1;
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected retire records are queued
// per instruction and popped when the controller pulses retire.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [31:0]               instr;
  logic                      br_eq, br_lt, br_un;
  logic                      ir_we, pc_we, rf_we, pc_sel, a_sel, b_sel, retire, halted;
  logic [IMM_TYPE_WIDTH-1:0] imm_sel;
  logic [ALUOP_WIDTH-1:0]    alu_sel;
  logic [2:0]                ld_sel;
  logic [1:0]                wb_sel, fault_cause;

  multicycle_controller_if #(.DWIDTH(32)) mif ();

  multicycle_controller #(.DWIDTH(32), .IMEM_WAIT_MAX(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .mem         (mif),
    .br_eq       (br_eq),
    .br_lt       (br_lt),
    .br_un       (br_un),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .pc_sel      (pc_sel),
    .imm_sel     (imm_sel),
    .a_sel       (a_sel),
    .b_sel       (b_sel),
    .alu_sel     (alu_sel),
    .ld_sel      (ld_sel),
    .wb_sel      (wb_sel),
    .retire      (retire),
    .halted      (halted),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         lat;
    logic       pc_sel;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic       b_sel;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc_n = 0, ir_cyc = 0, ready_cyc = 0, retire_cyc = 0, halt_cyc = 0;
  int   n_dreq = 0, n_ireq = 0, dcnt = 0, dmem_lat = 0, start = 0;
  bit   imem_en = 1'b1, rf_seen, wbe_outside, retired, halt_seen;
  logic [3:0]                wbe_mem;
  logic [2:0]                ld_mem;
  logic [10:0]               snap_ctl;
  logic                      snap_ireq, snap_br_un, snap_a;
  logic [ALUOP_WIDTH-1:0]    snap_alu;
  logic [IMM_TYPE_WIDTH-1:0] snap_imm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic clear_stats();
    rf_seen = 0; wbe_outside = 0; retired = 0; halt_seen = 0;
    n_dreq = 0; n_ireq = 0; wbe_mem = '0; ld_mem = '0;
    ir_cyc = 0; ready_cyc = 0; retire_cyc = 0; halt_cyc = 0;
  endtask

  // One clock: drive memory readies, sample at negedge, advance to posedge+1.
  task automatic cyc();
    exp_t e;
    bit   req_now;
    mif.imem_ready = imem_en;
    mif.dmem_ready = mif.dmem_req && (dcnt >= dmem_lat);
    @(negedge clk);
    cyc_n++;
    req_now   = mif.dmem_req;
    snap_ireq = mif.imem_req;
    snap_ctl  = {mif.imem_req, mif.dmem_req, mif.dmem_wbe, ir_we, pc_we, rf_we, retire, halted};
    if (ir_we) ir_cyc = cyc_n;
    if (mif.imem_req) n_ireq++;
    if (rf_we) rf_seen = 1;
    if (mif.dmem_req) begin
      n_dreq++;
      wbe_mem |= mif.dmem_wbe;
      ld_mem   = ld_sel;
      if (mif.dmem_ready) ready_cyc = cyc_n;
    end else if (mif.dmem_wbe != 4'b0000) begin
      wbe_outside = 1;
    end
    if (halted && !halt_seen) begin
      halt_seen = 1;
      halt_cyc  = cyc_n;
    end
    if (retire) begin
      retired    = 1;
      retire_cyc = cyc_n;
      snap_br_un = br_un;
      snap_alu   = alu_sel;
      snap_imm   = imm_sel;
      snap_a     = a_sel;
      if (sb_q.size() == 0) begin
        chk("sb.unexpected_retire", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({e.tag, ".lat"},    cyc_n - ir_cyc + 1, e.lat);
        chk({e.tag, ".pc_sel"}, pc_sel, e.pc_sel);
        chk({e.tag, ".wb_sel"}, wb_sel, e.wb_sel);
        chk({e.tag, ".rf_we"},  rf_we,  e.rf_we);
        chk({e.tag, ".b_sel"},  b_sel,  e.b_sel);
      end
    end
    @(posedge clk);
    dcnt = req_now ? dcnt + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst.ctl", {21'd0, snap_ctl}, 32'd0);
    chk("rst.fault_cause", fault_cause, FAULT_NONE);
    rst  = 1'b0;
    dcnt = 0;
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input int lat,
                     input logic pcs, input logic [1:0] wbs, input logic rfw, input logic bs);
    exp_t e;
    instr = ins;
    clear_stats();
    e.tag = tag; e.lat = lat; e.pc_sel = pcs; e.wb_sel = wbs; e.rf_we = rfw; e.b_sel = bs;
    sb_q.push_back(e);
    start = cyc_n;
    for (int i = 0; i < 400 && !retired && !halt_seen; i++) cyc();
    if (!retired) begin
      chk({tag, ".timeout"}, 32'd0, 32'd1);
      sb_q.delete();
    end
    chk({tag, ".ir_cyc"}, ir_cyc - start, 32'd1);
  endtask

  task automatic run_fault(input string tag, input logic [31:0] ins, input logic [1:0] cause);
    instr = ins;
    clear_stats();
    start = cyc_n;
    for (int i = 0; i < 400 && !halt_seen; i++) cyc();
    chk({tag, ".halt_cyc"}, halt_cyc - start, 32'd3);
    chk({tag, ".cause"}, fault_cause, cause);
    n_ireq = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk({tag, ".sticky_req"}, n_ireq, 32'd0);
    chk({tag, ".sticky_halt"}, halted, 1'b1);
    do_reset();
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0050_0093; br_eq = 1'b0; br_lt = 1'b0;
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run("addi", 32'h0050_0093, 4, PC_PLUS_4, WB_ALU, 1'b1, B_IMM);
    chk("addi.alu", snap_alu, ALU_ADD);
    chk("addi.imm", snap_imm, IMM_I);
    run("add", 32'h0020_81B3, 4, PC_PLUS_4, WB_ALU, 1'b1, B_REG);
    run("srai", 32'h4020_D093, 4, PC_PLUS_4, WB_ALU, 1'b1, B_IMM);
    chk("srai.alu", snap_alu, ALU_SRA);

    dmem_lat = 3;
    run("lw_wait", 32'h0000_A283, 8, PC_PLUS_4, WB_MEM, 1'b1, B_IMM);
    chk("lw_wait.dreq_cycles", n_dreq, 32'd4);
    chk("lw_wait.ld_sel", ld_mem, LD_WORD);
    chk("lw_wait.wb_after_ready", retire_cyc - ready_cyc, 32'd1);
    dmem_lat = 0;
    run("lw", 32'h0000_A283, 5, PC_PLUS_4, WB_MEM, 1'b1, B_IMM);

    br_eq = 1'b1;
    run("beq_taken", 32'h0020_8463, 4, PC_ALU, WB_ALU, 1'b0, B_IMM);
    chk("beq_taken.rf_never", rf_seen, 1'b0);
    br_eq = 1'b0;
    run("beq_not", 32'h0020_8463, 4, PC_PLUS_4, WB_ALU, 1'b0, B_IMM);
    chk("beq_not.rf_never", rf_seen, 1'b0);
    br_lt = 1'b1;
    run("bltu_taken", 32'h0020_E463, 4, PC_ALU, WB_ALU, 1'b0, B_IMM);
    chk("bltu_taken.br_un", snap_br_un, 1'b1);
    run("bge_not", 32'h0020_D463, 4, PC_PLUS_4, WB_ALU, 1'b0, B_IMM);
    chk("bge_not.br_un", snap_br_un, 1'b0);
    br_lt = 1'b0;

    run("jal", 32'h0100_00EF, 4, PC_ALU, WB_PC, 1'b1, B_IMM);
    chk("jal.imm", snap_imm, IMM_J);
    chk("jal.a_sel", snap_a, A_PC);
    run("jalr", 32'h0001_00E7, 4, PC_ALU, WB_PC, 1'b1, B_IMM);

    dmem_lat = 2;
    run("sh", 32'h0020_9223, 6, PC_PLUS_4, WB_ALU, 1'b0, B_IMM);
    chk("sh.wbe", wbe_mem, STR_HALF);
    chk("sh.wbe_outside_mem", wbe_outside, 1'b0);
    chk("sh.rf_never", rf_seen, 1'b0);
    chk("sh.retire_on_ready", retire_cyc - ready_cyc, 32'd0);
    chk("sh.dreq_cycles", n_dreq, 32'd3);
    chk("sh.imm", snap_imm, IMM_S);
    dmem_lat = 0;
    run("sw", 32'h0020_A223, 4, PC_PLUS_4, WB_ALU, 1'b0, B_IMM);
    chk("sw.wbe", wbe_mem, STR_WORD);

    // Reset lands while a store waits in MEM.
    dmem_lat = 10;
    instr = 32'h0020_A223;
    clear_stats();
    for (int i = 0; i < 20 && n_dreq < 2; i++) cyc();
    chk("rst_mem.in_mem", n_dreq, 32'd2);
    rst = 1'b1;
    cyc();
    chk("rst_mem.ctl", {21'd0, snap_ctl}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_mem.fetch_next", snap_ireq, 1'b1);
    chk("rst_mem.no_retire", retired, 1'b0);
    dmem_lat = 0;
    do_reset();

    run_fault("illegal_ones", 32'hFFFF_FFFF, FAULT_ILLEGAL);
    run_fault("illegal_f7", 32'h4020_91B3, FAULT_ILLEGAL);
    run_fault("ecall", 32'h0000_0073, FAULT_SYSTEM);

    // Fetch watchdog: imem never ready.
    instr   = 32'h0050_0093;
    imem_en = 1'b0;
    do_reset();
    clear_stats();
    start = cyc_n;
    for (int i = 0; i < 400 && !halt_seen; i++) cyc();
    chk("fetch_tmo.req_cycles", n_ireq, 32'd255);
    chk("fetch_tmo.halt_cyc", halt_cyc - start, 32'd256);
    chk("fetch_tmo.cause", fault_cause, FAULT_FETCH);
    do_reset();

    // Reset mid-wait must restart the watchdog count.
    for (int i = 0; i < 100; i++) cyc();
    do_reset();
    clear_stats();
    for (int i = 0; i < 200; i++) cyc();
    chk("rst_wait.no_halt", halt_seen, 1'b0);
    imem_en = 1'b1;
    run("addi_after_wait", 32'h0050_0093, 4, PC_PLUS_4, WB_ALU, 1'b1, B_IMM);
    chk("sb.drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath and instruction width.
REQ-002 SHALL have parameter IMEM_WAIT_MAX, default 255, fetch wait-cycle limit before fault.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port instr  input  DWIDTH  contents of the instruction register (IR).
REQ-006 SHALL have port imem_req  output  1  fetch request; imem_ready  input  1  fetch data valid this cycle.
REQ-007 SHALL have port dmem_req  output  1  data access request; dmem_ready  input  1  access completes this cycle.
REQ-008 SHALL have port br_eq, br_lt  input  1 each; br_un  output  1  comparator signals.
REQ-009 SHALL have port ir_we, pc_we, rf_we  output  1 each  register write enables.
REQ-010 SHALL have ports pc_sel (1), imm_sel (IMM_TYPE_WIDTH), a_sel (1), b_sel (1), alu_sel (ALUOP_WIDTH), dmem_wbe (DWIDTH/8), ld_sel (3), wb_sel (2), all outputs, with existing control-signal encodings.
REQ-011 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-012 SHALL have ports halted  output  1 and fault_cause  output  2  (0 none, 1 illegal, 2 ecall/ebreak, 3 fetch timeout).

Function
REQ-013 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 FETCH: imem_req=1; on imem_ready, ir_we=1 for that cycle, next DECODE; else stay.
REQ-015 FETCH SHALL count wait cycles; reaching IMEM_WAIT_MAX without imem_ready -> HALT, fault_cause=3.
REQ-016 DECODE: unsupported opcode, or illegal funct3/funct7 for supported opcode -> HALT, fault_cause=1; SYSTEM opcode -> HALT, fault_cause=2; else EXEC.
REQ-017 EXEC: drive imm_sel/a_sel/b_sel/alu_sel/br_un per RV32I; LOAD/STORE -> MEM; all others -> WB.
REQ-018 MEM: dmem_req=1; STORE drives dmem_wbe (SB/SH/SW masks) only in MEM; LOAD drives ld_sel; stay until dmem_ready.
REQ-019 MEM with dmem_ready: STORE -> FETCH asserting pc_we=1, pc_sel=PC+4, retire=1; LOAD -> WB.
REQ-020 WB: rf_we=1 except BRANCH; pc_we=1; retire=1; next FETCH.
REQ-021 WB pc_sel SHALL be ALU for JAL, JALR, and taken branches (BEQ/BNE/BLT/BGE/BLTU/BGEU, br_un=1 for unsigned), else PC+4.
REQ-022 wb_sel SHALL be WB_PC for JAL/JALR, WB_MEM for loads, else WB_ALU.
REQ-023 Datapath select outputs SHALL hold decoded values through EXEC, MEM and WB of the same instruction.
REQ-024 ir_we, pc_we, rf_we, dmem_wbe, imem_req, dmem_req, retire SHALL be 0 in any state not listed as asserting them.
REQ-025 HALT: halted=1, all enables and requests 0; exit only by rst.
REQ-026 Latency with zero-wait memories: ALU/branch/jump 4 cycles, store 4, load 5.

Reset
REQ-027 rst=1 at any cycle, including mid-MEM or mid-FETCH wait, SHALL force FETCH, clear wait counter, halted=0, fault_cause=0.
REQ-028 During rst=1 all write enables, requests, dmem_wbe and retire SHALL be 0; imem_req first asserts the cycle after rst deasserts.

Structure
REQ-029 Opcodes, funct codes, IMM_*, ALU_*, PC_*/A_*/B_*/WB_*/LD_*/STR_* encodings and the state enumeration SHALL live in the shared control definitions.
REQ-030 Combinational RV32I field decode SHALL be sub-module instr_decoder (instr -> selects plus illegal/system flags); FSM and wait counter stay in multicycle_controller.

Verification
REQ-031 addi x1,x0,5 (0x00500093), imem_ready=1 always -> ir_we cycle 1, rf_we+pc_we+retire cycle 4, wb_sel=WB_ALU, b_sel=B_IMM.
REQ-032 lw with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, ld_sel=LD_WORD, rf_we with wb_sel=WB_MEM one cycle after ready.
REQ-033 beq with br_eq=1 then br_eq=0 -> WB pc_sel=PC_ALU then PC_PLUS_4, rf_we=0 both.
REQ-034 sh -> dmem_wbe=STR_HALF only during MEM, rf_we never 1, retire on dmem_ready cycle.
REQ-035 instr=0xFFFFFFFF -> HALT after DECODE, fault_cause=1; ecall (0x00000073) -> fault_cause=2; imem_ready held 0 -> fault_cause=3 after 255 cycles.
REQ-036 rst pulsed during MEM of a store -> dmem_req and dmem_wbe 0 in reset cycle, FETCH next, no retire.
